vga_pattern_gen: RTL
====================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch/sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch/sync widths in lines.
REQ-005 SHALL have parameter COLOR_BITS, default 1, bits per colour channel (1..8).
REQ-006 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel (>=1).
REQ-007 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-008 SHALL have port: clk  input  1  system clock, single clock domain.
REQ-009 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-010 SHALL have port: mode  input  2  pattern select (0 solid white, 1 colour bars, 2 checkerboard, 3 moving bar).
REQ-011 SHALL have ports: vga_hsync, vga_vsync  output  1 each  sync pulses, polarity per SYNC_POL.
REQ-012 SHALL have ports: vga_r, vga_g, vga_b  output  COLOR_BITS each  colour channels.
REQ-013 SHALL have port: vga_de  output  1  high during active video.
REQ-014 SHALL have port: frame_start  output  1  one-clk pulse when pixel (0,0) is presented.

Function
REQ-015 SHALL generate pix_en internally: one clk-wide pulse every CLK_DIV clk cycles (constant high when CLK_DIV=1); no derived clocks.
REQ-016 SHALL advance h_cnt on pix_en, 0..H_TOTAL-1, H_TOTAL = sum of horizontal parameters, wrapping to 0.
REQ-017 SHALL advance v_cnt only on pix_en with h_cnt wrap, 0..V_TOTAL-1, wrapping to 0.
REQ-018 SHALL define active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE); sync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), likewise vertically.
REQ-019 SHALL register all outputs on pix_en; outputs for pixel (h,v) appear one pixel period after counters reach (h,v); syncs, de, colour mutually aligned.
REQ-020 SHALL drive colour all-zero whenever vga_de is low, in every mode.
REQ-021 SHALL sample mode only when both counters wrap (frame boundary); mode changes mid-frame take effect next frame.
REQ-022 Mode 0 SHALL output all channels at full scale (all ones).
REQ-023 Mode 1 SHALL output 8 vertical bars of H_ACTIVE/8 px, index b = x/(H_ACTIVE/8) clamped to 7: r=b[1], g=b[2], b=b[0] inverted order giving white, yellow, cyan, green, magenta, red, blue, black; each bit expanded to full scale.
REQ-024 Mode 2 SHALL output full-scale white when x[5] XOR y[5] = 1, else black (32x32 squares).
REQ-025 Mode 3 SHALL output white for x in [bar_pos, bar_pos+16), black elsewhere; no wrap of bar across right edge.
REQ-026 bar_pos SHALL increment by 1 at each frame boundary and wrap to 0 after H_ACTIVE-16.
REQ-027 frame_start SHALL be a single clk pulse coincident with the pix_en that presents pixel (0,0).

Reset
REQ-028 While reset is high SHALL set divider, h_cnt, v_cnt, bar_pos to 0 and latched mode to 0.
REQ-029 While reset is high SHALL drive syncs inactive (~SYNC_POL), vga_de 0, colours 0, frame_start 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; first pix_en after deassert begins at (0,0) with mode resampled.

Structure
REQ-031 Shared package vga_pkg SHALL hold mode encodings (MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_BAR) and default 640x480 timing constants.
REQ-032 Counter/sync generation SHALL be a sub-module vga_timing (pix_en, h_cnt, v_cnt, active, raw syncs, frame wrap); pattern logic and output registers in vga_pattern_gen.
REQ-033 Implementation SHALL be 120-400 lines RTL, no vendor primitives.

Verification
REQ-034 Defaults, mode 0, run 2 frames -> hsync period 1600 clk, low 192 clk; vsync period 840000 clk, low 2 lines; de high 640 px x 480 lines; colour 1 when de.
REQ-035 COLOR_BITS=4, mode 1 -> line 10 pixels 0,80,160,...,560 read F/F/F, F/F/0, 0/F/F, 0/F/0, F/0/F, F/0/0, 0/0/F, 0/0/0.
REQ-036 Mode 2 -> pixel (31,0)=black, (32,0)=white, (32,32)=black; blanking always 0.
REQ-037 Mode 3 over 3 frames -> bar starts x=0,1,2; force bar_pos=624 -> next frame bar_pos=0.
REQ-038 Switch mode 0->2 at line 100 -> rest of frame stays mode 0; next frame mode 2; reset at (300,200) -> outputs idle, restart at (0,0) with frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern encodings,
// default 640x480@60 timing and a counter-width helper.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BAR   = 2'd3
    } vga_mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int BAR_WIDTH = 16;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider plus horizontal/vertical raster counters and the raw
// (polarity-free) sync and active-video decodes derived from them.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = 2,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = cnt_width(H_TOTAL),
    localparam int VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          at_origin,
    output logic          frame_wrap
);

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam int DW = cnt_width(CLK_DIV);
            logic [DW-1:0] div_cnt;

            always_ff @(posedge clk) begin
                if (reset)
                    div_cnt <= '0;
                else if (div_cnt == DW'(CLK_DIV - 1))
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + 1'b1;
            end

            assign pix_en = (div_cnt == DW'(CLK_DIV - 1));
        end
    endgenerate

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hsync_act  = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                        (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_act  = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                        (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
    assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
    assign frame_wrap = pix_en && h_last && v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: selects one of four patterns per frame and
// registers colour, sync, data-enable and frame_start on each pixel enable.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int COLOR_BITS = 1,
    parameter int CLK_DIV    = 2,
    parameter bit SYNC_POL   = 1'b0,
    localparam int HW        = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW        = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  vga_de,
    output logic                  frame_start
);

    localparam int BAR_SEG = H_ACTIVE / 8;

    logic          pix_en;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          hsync_act;
    logic          vsync_act;
    logic          at_origin;
    logic          frame_wrap;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hsync_act  (hsync_act),
        .vsync_act  (vsync_act),
        .at_origin  (at_origin),
        .frame_wrap (frame_wrap)
    );

    vga_mode_e   mode_q;
    vga_mode_e   mode_sel;
    logic [15:0] bar_pos;
    logic [15:0] x_ext;
    logic [15:0] y_ext;
    logic [15:0] bar_idx;
    logic [2:0]  rgb;

    // Pixel (0,0) already uses the live mode input so that the frame after
    // a reset picks up the current selection, not the reset value.
    assign mode_sel = at_origin ? vga_mode_e'(mode) : mode_q;
    assign x_ext    = 16'(h_cnt);
    assign y_ext    = 16'(v_cnt);
    assign bar_idx  = x_ext / 16'(BAR_SEG);

    always_comb begin
        rgb = 3'b000;
        unique case (mode_sel)
            MODE_SOLID: rgb = 3'b111;
            MODE_BARS:  begin
                if (bar_idx > 16'd7)
                    rgb = 3'b000;
                else
                    rgb = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
            end
            MODE_CHECK: rgb = {3{x_ext[5] ^ y_ext[5]}};
            MODE_BAR:   rgb = {3{(x_ext >= bar_pos) &&
                                 (x_ext < bar_pos + 16'(BAR_WIDTH))}};
        endcase
        if (!active)
            rgb = 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_SOLID;
            bar_pos     <= '0;
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            vga_de      <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && at_origin;
            if (pix_en) begin
                if (at_origin)
                    mode_q <= mode_sel;
                if (frame_wrap)
                    bar_pos <= (bar_pos >= 16'(H_ACTIVE - BAR_WIDTH)) ? '0
                                                                      : bar_pos + 16'd1;
                vga_hsync <= hsync_act ? SYNC_POL : ~SYNC_POL;
                vga_vsync <= vsync_act ? SYNC_POL : ~SYNC_POL;
                vga_de    <= active;
                vga_r     <= {COLOR_BITS{rgb[2]}};
                vga_g     <= {COLOR_BITS{rgb[1]}};
                vga_b     <= {COLOR_BITS{rgb[0]}};
            end
        end
    end

endmodule
